// File: rtl/flood_engine.sv
// Flood-it game engine: raster PAINT/GROW passes over an on-chip board,
// with move legality checks, try counting and win/lose detection.
module flood_engine #(
    parameter int MAX_SIZE   = 26,
    parameter int COLOR_BITS = 3,
    parameter int TRY_BITS   = 8,
    localparam int RC_W      = $clog2(MAX_SIZE)
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [4:0]            SIZE,
    input  logic [3:0]            COLOR_NUM,
    input  logic [TRY_BITS-1:0]   TRY_LIMIT,
    input  logic                  LOAD_EN,
    input  logic [RC_W-1:0]       LOAD_ROW,
    input  logic [RC_W-1:0]       LOAD_COL,
    input  logic [COLOR_BITS-1:0] LOAD_COLOR,
    input  logic                  NEW_GAME,
    input  logic                  MOVE_VALID,
    input  logic [COLOR_BITS-1:0] MOVE_COLOR,
    output logic                  MOVE_READY,
    input  logic [RC_W-1:0]       RD_ROW,
    input  logic [RC_W-1:0]       RD_COL,
    output logic [COLOR_BITS-1:0] RD_COLOR,
    output logic                  RD_FLOODED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  MOVE_ERR,
    output logic [TRY_BITS-1:0]   TRIES,
    output logic                  WON,
    output logic                  LOST
);

    localparam int CELLS = MAX_SIZE * MAX_SIZE;
    localparam int IW    = $clog2(CELLS);
    localparam int NW    = $clog2(MAX_SIZE + 1);

    typedef enum logic [1:0] {IDLE, PAINT, GROW, FINISH} state_t;
    state_t state, state_next;

    logic [COLOR_BITS-1:0] cell_color [CELLS];
    logic [CELLS-1:0]      flooded;

    logic [NW-1:0]         n_eff;
    logic [3:0]            color_num;
    logic [TRY_BITS-1:0]   try_limit;
    logic [COLOR_BITS-1:0] target;
    logic                  counted;
    logic                  changed;
    logic [RC_W-1:0]       row;
    logic [RC_W-1:0]       col;

    logic [IW-1:0]         cur_idx, rd_idx, load_idx;
    logic                  rd_ok, load_ok;
    logic                  last_col, last_row, scan_end;
    logic                  start_game, move_take, move_bad, move_same, move_paint;
    logic                  nb_flooded, grow_hit, all_flooded;
    logic [TRY_BITS-1:0]   tries_next;
    logic                  lost_next;

    always_comb begin
        cur_idx  = IW'(row) * IW'(MAX_SIZE) + IW'(col);
        rd_idx   = IW'(RD_ROW) * IW'(MAX_SIZE) + IW'(RD_COL);
        load_idx = IW'(LOAD_ROW) * IW'(MAX_SIZE) + IW'(LOAD_COL);
        rd_ok    = (32'(RD_ROW) < MAX_SIZE) && (32'(RD_COL) < MAX_SIZE);
        load_ok  = (32'(LOAD_ROW) < MAX_SIZE) && (32'(LOAD_COL) < MAX_SIZE);
        last_col = (NW'(col) == n_eff - NW'(1));
        last_row = (NW'(row) == n_eff - NW'(1));
        scan_end = last_col && last_row;

        MOVE_READY = (state == IDLE) && !WON && !LOST;
        BUSY       = (state != IDLE);
        DONE       = (state == FINISH);
        start_game = (state == IDLE) && NEW_GAME;
        move_take  = MOVE_READY && MOVE_VALID && !NEW_GAME;
        move_bad   = move_take && (32'(MOVE_COLOR) >= 32'(color_num));
        move_same  = move_take && !move_bad && (MOVE_COLOR == cell_color[0]);
        move_paint = move_take && !move_bad && !move_same;
    end

    // Neighbour lookups read the live array, so cells flooded earlier in
    // the same pass already count.
    always_comb begin
        nb_flooded = 1'b0;
        if (row != '0)                      nb_flooded |= flooded[cur_idx - IW'(MAX_SIZE)];
        if (NW'(row) < n_eff - NW'(1))      nb_flooded |= flooded[cur_idx + IW'(MAX_SIZE)];
        if (col != '0)                      nb_flooded |= flooded[cur_idx - IW'(1)];
        if (NW'(col) < n_eff - NW'(1))      nb_flooded |= flooded[cur_idx + IW'(1)];
        grow_hit = (state == GROW) && !flooded[cur_idx] &&
                   (cell_color[cur_idx] == target) && nb_flooded;
    end

    always_comb begin
        all_flooded = 1'b1;
        for (int unsigned rr = 0; rr < MAX_SIZE; rr++) begin
            for (int unsigned cc = 0; cc < MAX_SIZE; cc++) begin
                if (rr < 32'(n_eff) && cc < 32'(n_eff) && !flooded[IW'(rr * MAX_SIZE + cc)])
                    all_flooded = 1'b0;
            end
        end
        if (counted && TRIES != '1) tries_next = TRIES + TRY_BITS'(1);
        else                        tries_next = TRIES;
        lost_next = !all_flooded && (try_limit != '0) && (tries_next >= try_limit);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_game)      state_next = GROW;
                else if (move_paint) state_next = PAINT;
                else if (move_same)  state_next = FINISH;
            end
            PAINT:  if (scan_end) state_next = GROW;
            GROW:   if (scan_end && !(changed || grow_hit)) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            TRIES      <= '0;
            WON        <= 1'b0;
            LOST       <= 1'b0;
            MOVE_ERR   <= 1'b0;
            RD_FLOODED <= 1'b0;
            flooded    <= '0;
            n_eff      <= NW'(MAX_SIZE);
            color_num  <= '0;
            try_limit  <= '0;
            target     <= '0;
            counted    <= 1'b0;
            changed    <= 1'b0;
            row        <= '0;
            col        <= '0;
        end else begin
            MOVE_ERR   <= move_bad;
            RD_FLOODED <= rd_ok ? flooded[rd_idx] : 1'b0;
            if (state == PAINT || state == GROW) begin
                if (scan_end) begin
                    row <= '0;
                    col <= '0;
                end else if (last_col) begin
                    row <= row + RC_W'(1);
                    col <= '0;
                end else begin
                    col <= col + RC_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start_game) begin
                        if (SIZE < 5'd2)                n_eff <= NW'(2);
                        else if (32'(SIZE) > MAX_SIZE)  n_eff <= NW'(MAX_SIZE);
                        else                            n_eff <= NW'(SIZE);
                        color_num <= COLOR_NUM;
                        try_limit <= TRY_LIMIT;
                        flooded   <= CELLS'(1);
                        TRIES     <= '0;
                        WON       <= 1'b0;
                        LOST      <= 1'b0;
                        target    <= cell_color[0];
                        counted   <= 1'b0;
                        changed   <= 1'b0;
                        row       <= '0;
                        col       <= '0;
                    end else if (move_paint) begin
                        target  <= MOVE_COLOR;
                        counted <= 1'b1;
                        row     <= '0;
                        col     <= '0;
                    end else if (move_same) begin
                        counted <= 1'b0;
                    end
                end
                GROW: begin
                    if (grow_hit) flooded[cur_idx] <= 1'b1;
                    if (scan_end)      changed <= 1'b0;
                    else if (grow_hit) changed <= 1'b1;
                end
                FINISH: begin
                    TRIES <= tries_next;
                    WON   <= all_flooded;
                    LOST  <= lost_next;
                end
                default: ;
            endcase
        end
    end

    // Colour storage carries no reset; the read port follows it.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            if (state == IDLE && LOAD_EN && load_ok) cell_color[load_idx] <= LOAD_COLOR;
            if (state == PAINT && flooded[cur_idx])  cell_color[cur_idx] <= target;
        end
        RD_COLOR <= rd_ok ? cell_color[rd_idx] : '0;
    end

endmodule

// File: tb/tb_flood_engine.sv
// Self-checking bench for flood_engine: directed scenarios plus random games
// compared against a breadth-first flood-fill reference model.
module tb_flood_engine;

    localparam int MS  = 26;
    localparam int CB  = 3;
    localparam int TBW = 8;
    localparam int RC  = $clog2(MS);

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic [4:0]    SIZE = '0;
    logic [3:0]    COLOR_NUM = '0;
    logic [TBW-1:0] TRY_LIMIT = '0;
    logic          LOAD_EN = 1'b0;
    logic [RC-1:0] LOAD_ROW = '0, LOAD_COL = '0;
    logic [CB-1:0] LOAD_COLOR = '0;
    logic          NEW_GAME = 1'b0;
    logic          MOVE_VALID = 1'b0;
    logic [CB-1:0] MOVE_COLOR = '0;
    logic          MOVE_READY;
    logic [RC-1:0] RD_ROW = '0, RD_COL = '0;
    logic [CB-1:0] RD_COLOR;
    logic          RD_FLOODED, BUSY, DONE, MOVE_ERR, WON, LOST;
    logic [TBW-1:0] TRIES;

    always #5 CLOCK = ~CLOCK;

    flood_engine #(.MAX_SIZE(MS), .COLOR_BITS(CB), .TRY_BITS(TBW)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .SIZE(SIZE), .COLOR_NUM(COLOR_NUM),
        .TRY_LIMIT(TRY_LIMIT), .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW),
        .LOAD_COL(LOAD_COL), .LOAD_COLOR(LOAD_COLOR), .NEW_GAME(NEW_GAME),
        .MOVE_VALID(MOVE_VALID), .MOVE_COLOR(MOVE_COLOR), .MOVE_READY(MOVE_READY),
        .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_COLOR(RD_COLOR),
        .RD_FLOODED(RD_FLOODED), .BUSY(BUSY), .DONE(DONE), .MOVE_ERR(MOVE_ERR),
        .TRIES(TRIES), .WON(WON), .LOST(LOST)
    );

    int errors = 0;
    int checks = 0;

    int mcol [MS][MS];
    bit mfl  [MS][MS];
    int m_n, m_cn, m_lim, m_tries;
    bit m_won, m_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic int clamp_n(input int size);
        if (size < 2)  return 2;
        if (size > MS) return MS;
        return size;
    endfunction

    // Breadth-first growth from every flooded cell through cells of colour t.
    function automatic void m_grow(input int t);
        int q[$];
        int dr[4] = '{-1, 1, 0, 0};
        int dc[4] = '{0, 0, -1, 1};
        for (int r = 0; r < m_n; r++)
            for (int c = 0; c < m_n; c++)
                if (mfl[r][c]) q.push_back(r * MS + c);
        while (q.size() > 0) begin
            int p, r, c;
            p = q.pop_front();
            r = p / MS;
            c = p % MS;
            for (int k = 0; k < 4; k++) begin
                int nr, nc;
                nr = r + dr[k];
                nc = c + dc[k];
                if (nr >= 0 && nr < m_n && nc >= 0 && nc < m_n &&
                    !mfl[nr][nc] && mcol[nr][nc] == t) begin
                    mfl[nr][nc] = 1'b1;
                    q.push_back(nr * MS + nc);
                end
            end
        end
    endfunction

    function automatic void m_finish(input bit counted);
        if (counted && m_tries < 255) m_tries++;
        m_won = 1'b1;
        for (int r = 0; r < m_n; r++)
            for (int c = 0; c < m_n; c++)
                if (!mfl[r][c]) m_won = 1'b0;
        m_lost = !m_won && m_lim != 0 && m_tries >= m_lim;
    endfunction

    function automatic bit m_ready();
        return !m_won && !m_lost;
    endfunction

    task automatic load_cell(input int r, input int c, input int color);
        LOAD_EN = 1'b1;
        LOAD_ROW = RC'(r);
        LOAD_COL = RC'(c);
        LOAD_COLOR = CB'(color);
        tick();
        LOAD_EN = 1'b0;
    endtask

    task automatic load_board(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                load_cell(r, c, mcol[r][c]);
    endtask

    task automatic new_game(input int size, input int cn, input int lim);
        SIZE = 5'(size);
        COLOR_NUM = 4'(cn);
        TRY_LIMIT = TBW'(lim);
        NEW_GAME = 1'b1;
        tick();
        NEW_GAME = 1'b0;
        m_n = clamp_n(size);
        m_cn = cn;
        m_lim = lim;
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
                mfl[r][c] = 1'b0;
        mfl[0][0] = 1'b1;
        m_tries = 0;
        m_won = 1'b0;
        m_lost = 1'b0;
        m_grow(mcol[0][0]);
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (DONE !== 1'b1 && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic post_checks(input string tag);
        chk({tag, "_done_low"}, DONE, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_tries"}, TRIES, m_tries);
        chk({tag, "_won"}, WON, m_won);
        chk({tag, "_lost"}, LOST, m_lost);
        chk({tag, "_ready"}, MOVE_READY, m_ready());
    endtask

    task automatic complete(input string tag, input bit counted, input int exp_lat);
        int lat;
        wait_done(60000, lat);
        chk({tag, "_done"}, DONE, 1);
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
        m_finish(counted);
        tick();
        post_checks(tag);
    endtask

    task automatic readback(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < m_n; r++) begin
            for (int c = 0; c < m_n; c++) begin
                RD_ROW = RC'(r);
                RD_COL = RC'(c);
                tick();
                if (RD_FLOODED !== mfl[r][c] || RD_COLOR !== CB'(mcol[r][c])) bad++;
            end
        end
        chk({tag, "_board_mismatches"}, bad, 0);
    endtask

    task automatic do_move(input int color, input string tag);
        MOVE_VALID = 1'b1;
        MOVE_COLOR = CB'(color);
        tick();
        MOVE_VALID = 1'b0;
        if (color >= m_cn) begin
            chk({tag, "_err"}, MOVE_ERR, 1);
            chk({tag, "_err_busy"}, BUSY, 0);
            tick();
            chk({tag, "_err_pulse"}, MOVE_ERR, 0);
            chk({tag, "_err_tries"}, TRIES, m_tries);
        end else if (color == mcol[0][0]) begin
            complete({tag, "_same"}, 1'b0, 0);
        end else begin
            for (int r = 0; r < m_n; r++)
                for (int c = 0; c < m_n; c++)
                    if (mfl[r][c]) mcol[r][c] = color;
            m_grow(color);
            complete({tag, "_paint"}, 1'b1, -1);
        end
        readback(tag);
    endtask

    task automatic set_line(input int r0, input int c0, input int r1, input int c1);
        int ra, rb, ca, cb;
        ra = (r0 < r1) ? r0 : r1;  rb = (r0 < r1) ? r1 : r0;
        ca = (c0 < c1) ? c0 : c1;  cb = (c0 < c1) ? c1 : c0;
        for (int r = ra; r <= rb; r++)
            for (int c = ca; c <= cb; c++)
                mcol[r][c] = 1;
    endtask

    initial begin
        int v;
        // Reset state
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", MOVE_READY, 1);
        chk("rst_tries", TRIES, 0);
        chk("rst_won", WON, 0);
        chk("rst_lost", LOST, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", MOVE_ERR, 0);
        chk("rst_rd_flooded", RD_FLOODED, 0);

        // 3x3 uniform board: one changing GROW pass, one quiet pass
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mcol[r][c] = 2;
        load_board(3);
        new_game(3, 3, 0);
        complete("uniform", 1'b0, 18);
        readback("uniform");

        // Row0 {0,1,1}, rest 1: one move wins
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mcol[r][c] = 1;
        mcol[0][0] = 0;
        load_board(3);
        new_game(3, 2, 5);
        complete("onemove_ng", 1'b0, -1);
        do_move(1, "onemove");

        // Illegal colours, then corner colour, then a counted move
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mcol[r][c] = $urandom_range(0, 3);
        mcol[0][0] = 0;
        mcol[2][2] = 3;
        load_board(3);
        new_game(3, 4, 0);
        complete("errs_ng", 1'b0, -1);
        do_move(6, "bad6");
        do_move(4, "bad4");
        do_move(0, "corner");
        do_move(3, "move3");

        // Two-move board with TRY_LIMIT=1 -> LOST, later moves ignored
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mcol[r][c] = 1;
        mcol[0][0] = 0;
        mcol[0][2] = 2;
        load_board(3);
        new_game(3, 3, 1);
        complete("lost_ng", 1'b0, -1);
        do_move(1, "lost");
        chk("lost_flag", LOST, 1);
        MOVE_VALID = 1'b1;
        MOVE_COLOR = 3'd2;
        tick();
        tick();
        MOVE_VALID = 1'b0;
        chk("lost_ignored_busy", BUSY, 0);
        chk("lost_ignored_err", MOVE_ERR, 0);
        chk("lost_ignored_tries", TRIES, 1);

        // Random games, including clamped sizes
        for (int g = 0; g < 6; g++) begin
            int size, cn, lim, n;
            size = $urandom_range(0, 7);
            cn = $urandom_range(2, 5);
            lim = $urandom_range(0, 4);
            n = clamp_n(size);
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++)
                    mcol[r][c] = $urandom_range(0, cn - 1);
            load_board(n);
            new_game(size, cn, lim);
            complete($sformatf("rg%0d_ng", g), 1'b0, -1);
            readback($sformatf("rg%0d_ng", g));
            for (int k = 0; k < 10 && m_ready(); k++)
                do_move($urandom_range(0, cn), $sformatf("rg%0d_m%0d", g, k));
        end

        // Spiral corridor on a clamped 26x26 board: many GROW passes
        for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++) begin
                v = $urandom_range(0, 2);
                mcol[r][c] = (v == 0) ? 0 : v + 1;
            end
        end
        set_line(0, 0, 0, 25);
        set_line(0, 25, 25, 25);
        set_line(25, 25, 25, 2);
        set_line(25, 2, 2, 2);
        set_line(2, 2, 2, 23);
        set_line(2, 23, 23, 23);
        load_board(MS);
        new_game(30, 4, 0);
        complete("spiral", 1'b0, -1);
        readback("spiral");

        // Reset in the middle of GROW
        new_game(30, 4, 0);
        repeat (1000) tick();
        chk("midrst_busy_before", BUSY, 1);
        load_cell(1, 1, 6);
        RD_ROW = '0;
        RD_COL = '0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_busy", BUSY, 0);
        chk("midrst_tries", TRIES, 0);
        chk("midrst_ready", MOVE_READY, 1);
        chk("midrst_rd_flooded", RD_FLOODED, 0);
        load_cell(2, 2, 5);
        mcol[2][2] = 5;
        RD_ROW = RC'(1);
        RD_COL = RC'(1);
        tick();
        chk("midrst_busy_load_dropped", RD_COLOR, mcol[1][1]);
        RD_ROW = RC'(2);
        RD_COL = RC'(2);
        tick();
        chk("midrst_load_color", RD_COLOR, 5);
        chk("midrst_load_flooded", RD_FLOODED, 0);
        MOVE_VALID = 1'b1;
        MOVE_COLOR = '0;
        tick();
        MOVE_VALID = 1'b0;
        chk("midrst_colornum_zero_err", MOVE_ERR, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
